gtxe2_qpll_reset_seq: RTL and testbench

//  Upstream control stage for the GTXE2 common quad PLL. Owns QPLLPD, QPLLRESET,

---
 rtl/gtxe2_qpll_pkg.sv | 64 ++++++
 rtl/gtxe2_sync2.sv | 29 ++
 rtl/gtxe2_qpll_reset_seq.sv | 182 ++++++++++++++++++
 tb/tb_gtxe2_qpll_reset_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gtxe2_qpll_pkg.sv
// rtl/gtxe2_qpll_pkg.sv - shared state encoding, widths and control decode for the QPLL reset sequencer
//
// Purpose: state encoding, STATE / RETRY_CNT widths and the per-state QPLL
// control pattern used by gtxe2_qpll_reset_seq.
// Ports: none (package).

package gtxe2_qpll_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_PWRDN     = 3'd1,
        ST_RST_Q     = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_STABLE    = 3'd4,
        ST_READY     = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    typedef struct packed {
        logic pd;
        logic reset;
        logic locken;
        logic outreset;
        logic done;
        logic fail;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{pd: 1'b1, reset: 1'b1, locken: 1'b0,
                                     outreset: 1'b1, done: 1'b0, fail: 1'b0};

    // Control pattern driven while sitting in a given state. The PLL stays
    // fully held (PD/RESET/OUTRESET) in IDLE, PWRDN and FAULT so a failed
    // QPLL never toggles QPLLOUTCLK into the downstream transceivers.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = CTRL_RESET;
        case (s)
            ST_RST_Q: begin
                c.pd = 1'b0;
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                c.pd     = 1'b0;
                c.reset  = 1'b0;
                c.locken = 1'b1;
            end
            ST_READY: begin
                c.pd       = 1'b0;
                c.reset    = 1'b0;
                c.locken   = 1'b1;
                c.outreset = 1'b0;
                c.done     = 1'b1;
            end
            ST_FAULT: begin
                c.fail = 1'b1;
            end
            default: c = CTRL_RESET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gtxe2_sync2.sv
// rtl/gtxe2_sync2.sv - two-flop synchronizer with synchronous active-high reset
//
// Purpose: bring an asynchronous single-bit status into the clk domain.
// Ports:
//   clk  in  destination clock
//   rst  in  synchronous active-high reset, clears both stages
//   d    in  asynchronous input
//   q    out synchronized output (2-cycle latency)

module gtxe2_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gtxe2_qpll_reset_seq.sv
// rtl/gtxe2_qpll_reset_seq.sv - GTXE2 QPLL power-up/reset/lock sequencer with retry and lock qualification
//
// Purpose: drives QPLLPD / QPLLRESET / QPLLLOCKEN / QPLLOUTRESET through the
// power-down, reset and lock phases, qualifies lock over a stability window,
// retries on timeout or refclk loss and reports DONE / FAIL.
// Ports:
//   DRPCLK          in   free-running system clock
//   RST             in   synchronous active-high reset
//   START           in   start / restart (level, honoured in IDLE/READY/FAULT)
//   QPLLLOCK        in   QPLL lock (asynchronous)
//   QPLLREFCLKLOST  in   QPLL reference clock lost (asynchronous)
//   QPLLPD          out  QPLL power-down
//   QPLLRESET       out  QPLL reset
//   QPLLLOCKEN      out  lock-detector enable
//   QPLLOUTRESET    out  QPLL output-divider reset
//   DONE            out  lock qualified
//   FAIL            out  retries exhausted
//   RETRY_CNT       out  retries used in the current sequence
//   STATE           out  current state encoding

module gtxe2_qpll_reset_seq
    import gtxe2_qpll_pkg::*;
#(
    parameter int PD_CYCLES    = 32,
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 256,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 16
) (
    input  logic               DRPCLK,
    input  logic               RST,
    input  logic               START,
    input  logic               QPLLLOCK,
    input  logic               QPLLREFCLKLOST,
    output logic               QPLLPD,
    output logic               QPLLRESET,
    output logic               QPLLLOCKEN,
    output logic               QPLLOUTRESET,
    output logic               DONE,
    output logic               FAIL,
    output logic [RETRY_W-1:0] RETRY_CNT,
    output logic [STATE_W-1:0] STATE
);

    // Terminal counts: a state with terminal N-1 lasts exactly N cycles
    // because cnt is cleared on the entry edge.
    localparam logic [CNT_W-1:0]   PD_TC     = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RESET_TC  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_TC = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_inc;
    logic               retry_clr;
    logic               retry_req;
    ctrl_t              ctrl_q;
    ctrl_t              ctrl_d;
    logic               lock_s;
    logic               lost_s;

    gtxe2_sync2 u_sync_lock (
        .clk (DRPCLK),
        .rst (RST),
        .d   (QPLLLOCK),
        .q   (lock_s)
    );

    gtxe2_sync2 u_sync_lost (
        .clk (DRPCLK),
        .rst (RST),
        .d   (QPLLREFCLKLOST),
        .q   (lost_s)
    );

    // State, counter, retry counter and registered controls all advance on
    // the same edge so the outputs never lag the state by a cycle.
    always_ff @(posedge DRPCLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            retry_cnt <= '0;
            ctrl_q    <= CTRL_RESET;
        end else begin
            state  <= next_state;
            ctrl_q <= ctrl_d;
            if (next_state != state) begin
                cnt <= '0;
            end else begin
                // Wraps harmlessly in IDLE/READY/FAULT, which have no terminal count.
                cnt <= cnt + 1'b1;
            end
            if (retry_clr) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        retry_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    next_state = ST_PWRDN;
                    retry_clr  = 1'b1;
                end
            end
            ST_PWRDN: begin
                if (cnt == PD_TC) next_state = ST_RST_Q;
            end
            ST_RST_Q: begin
                if (cnt == RESET_TC) next_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Refclk loss beats lock; lock beats a coincident timeout.
                if (lost_s) begin
                    retry_req = 1'b1;
                end else if (lock_s) begin
                    next_state = ST_STABLE;
                end else if (cnt == TIMEOUT_TC) begin
                    retry_req = 1'b1;
                end
            end
            ST_STABLE: begin
                // A glitch restarts the wait (fresh timeout) without burning a retry.
                if (!lock_s || lost_s) begin
                    next_state = ST_WAIT_LOCK;
                end else if (cnt == STABLE_TC) begin
                    next_state = ST_READY;
                end
            end
            ST_READY: begin
                if (!lock_s || lost_s || START) begin
                    next_state = ST_PWRDN;
                    retry_clr  = 1'b1;
                end
            end
            ST_FAULT: begin
                if (START) begin
                    next_state = ST_PWRDN;
                    retry_clr  = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (retry_req) begin
            if (retry_cnt < RETRY_MAX) begin
                next_state = ST_PWRDN;
                retry_inc  = 1'b1;
            end else begin
                next_state = ST_FAULT;
            end
        end
    end

    // Controls are decoded from the state being entered and registered.
    always_comb begin
        ctrl_d = state_ctrl(next_state);
    end

    assign QPLLPD       = ctrl_q.pd;
    assign QPLLRESET    = ctrl_q.reset;
    assign QPLLLOCKEN   = ctrl_q.locken;
    assign QPLLOUTRESET = ctrl_q.outreset;
    assign DONE         = ctrl_q.done;
    assign FAIL         = ctrl_q.fail;
    assign RETRY_CNT    = retry_cnt;
    assign STATE        = state;

endmodule

// File: tb/tb_gtxe2_qpll_reset_seq.sv
// tb/tb_gtxe2_qpll_reset_seq.sv - directed self-checking bench for gtxe2_qpll_reset_seq

module tb_gtxe2_qpll_reset_seq;

    localparam int S_IDLE   = 0;
    localparam int S_PWRDN  = 1;
    localparam int S_RST_Q  = 2;
    localparam int S_WAIT   = 3;
    localparam int S_STABLE = 4;
    localparam int S_READY  = 5;
    localparam int S_FAULT  = 6;

    logic       clk;
    logic       rst;
    logic       start;
    logic       lock;
    logic       lost;
    logic       pd;
    logic       qreset;
    logic       locken;
    logic       outreset;
    logic       done;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int tests_run;
    int tests_failed;

    gtxe2_qpll_reset_seq #(
        .PD_CYCLES    (4),
        .RESET_CYCLES (3),
        .LOCK_TIMEOUT (20),
        .LOCK_STABLE  (5),
        .MAX_RETRIES  (2),
        .CNT_W        (16)
    ) dut (
        .DRPCLK         (clk),
        .RST            (rst),
        .START          (start),
        .QPLLLOCK       (lock),
        .QPLLREFCLKLOST (lost),
        .QPLLPD         (pd),
        .QPLLRESET      (qreset),
        .QPLLLOCKEN     (locken),
        .QPLLOUTRESET   (outreset),
        .DONE           (done),
        .FAIL           (fail),
        .RETRY_CNT      (retry_cnt),
        .STATE          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 1'b0;
        lock  = 1'b0;
        lost  = 1'b0;
        step(3);

        // reset state
        check("rst_state", state, S_IDLE);
        check("rst_pd", pd, 1);
        check("rst_reset", qreset, 1);
        check("rst_outreset", outreset, 1);
        check("rst_locken", locken, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_retry", retry_cnt, 0);
        rst = 1'b0;
        step(1);
        check("idle_hold", state, S_IDLE);

        // 1: nominal sequence, lock 6 cycles into WAIT_LOCK
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            start = 1'b0;
            check("t1_pwrdn_state", state, S_PWRDN);
            check("t1_pwrdn_pd", pd, 1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t1_rstq_state", state, S_RST_Q);
            check("t1_rstq_pd", pd, 0);
            check("t1_rstq_reset", qreset, 1);
        end
        step(1);
        check("t1_wait_state", state, S_WAIT);
        check("t1_wait_reset", qreset, 0);
        check("t1_wait_locken", locken, 1);
        step(5);
        lock = 1'b1;
        step(7);
        check("t1_stable_state", state, S_STABLE);
        check("t1_done_early", done, 0);
        step(1);
        check("t1_ready_state", state, S_READY);
        check("t1_done", done, 1);
        check("t1_outreset", outreset, 0);
        check("t1_retry", retry_cnt, 0);

        // 4: lock loss in READY
        lock = 1'b0;
        step(2);
        check("t4_done_hold", done, 1);
        step(1);
        check("t4_done_drop", done, 0);
        check("t4_outreset", outreset, 1);
        check("t4_state", state, S_PWRDN);
        check("t4_retry", retry_cnt, 0);

        // 2: no lock -> three timed-out passes then FAULT
        for (int p = 0; p < 3; p++) begin
            step(7);
            check("t2_wait_entry", state, S_WAIT);
            check("t2_wait_retry", retry_cnt, p);
            step(19);
            check("t2_wait_last", state, S_WAIT);
            step(1);
            if (p < 2) begin
                check("t2_retry_state", state, S_PWRDN);
                check("t2_retry_cnt", retry_cnt, p + 1);
            end else begin
                check("t2_fault_state", state, S_FAULT);
                check("t2_fault_flag", fail, 1);
                check("t2_fault_retry", retry_cnt, 2);
                check("t2_fault_pd", pd, 1);
                check("t2_fault_reset", qreset, 1);
            end
        end
        lock = 1'b1;
        step(6);
        check("t2_fault_ignores_lock", state, S_FAULT);
        check("t2_fault_sticky", fail, 1);
        lock = 1'b0;
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("t2_restart_state", state, S_PWRDN);
        check("t2_restart_fail", fail, 0);
        check("t2_restart_retry", retry_cnt, 0);

        // 3: one-cycle lock drop on the 3rd STABLE cycle
        step(7);
        check("t3_wait", state, S_WAIT);
        lock = 1'b1;
        step(3);
        check("t3_stable1", state, S_STABLE);
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        step(1);
        check("t3_stable3", state, S_STABLE);
        step(1);
        check("t3_back_wait", state, S_WAIT);
        check("t3_retry", retry_cnt, 0);
        step(1);
        check("t3_restable", state, S_STABLE);
        step(4);
        check("t3_stable_last", state, S_STABLE);
        check("t3_done_early", done, 0);
        step(1);
        check("t3_ready", state, S_READY);
        check("t3_done", done, 1);

        // 5: refclk loss and lock together in WAIT_LOCK
        start = 1'b1;
        lock  = 1'b0;
        step(1);
        start = 1'b0;
        check("t5_forced_reseq", state, S_PWRDN);
        check("t5_forced_retry", retry_cnt, 0);
        step(7);
        check("t5_wait", state, S_WAIT);
        lock = 1'b1;
        lost = 1'b1;
        step(2);
        check("t5_no_stable", state, S_WAIT);
        step(1);
        check("t5_retry_state", state, S_PWRDN);
        check("t5_retry_cnt", retry_cnt, 1);
        lock = 1'b0;
        lost = 1'b0;

        // 6: START ignored mid-sequence, then RST pulse in WAIT_LOCK
        step(7);
        check("t6_wait", state, S_WAIT);
        check("t6_wait_retry", retry_cnt, 1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("t6_start_ignored", state, S_WAIT);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_state", state, S_IDLE);
        check("t6_pd", pd, 1);
        check("t6_reset", qreset, 1);
        check("t6_locken", locken, 0);
        check("t6_done", done, 0);
        check("t6_fail", fail, 0);
        check("t6_retry", retry_cnt, 0);
        step(1);
        check("t6_idle_hold", state, S_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
